sc_timing_gen: RTL and testbench
================================

SC_TIMING_GEN -- requirements
Module: sc_timing_gen

Interface
REQ-001 Parameter WIDTH, default 3: sequence-count width in bits.
REQ-002 Parameter DEPTH, default 8: count modulus; legal range 2..2^WIDTH.
REQ-003 Parameter SAT_MODE, default 0: 0 wraps at DEPTH-1, 1 saturates at DEPTH-1.
REQ-004 Parameter ICW, default 8: instruction-counter width in bits.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 rstsc  input  1  synchronous sequence clear, end of instruction.
REQ-008 inc  input  1  advance sequence count by one.
REQ-009 ld  input  1  synchronous load of ld_val.
REQ-010 ld_val  input  WIDTH  load value.
REQ-011 DATA_out  output  WIDTH  current sequence count, registered.
REQ-012 T_out  output  DEPTH  one-hot timing decode of DATA_out.
REQ-013 tc  output  1  terminal count, high when DATA_out == DEPTH-1.
REQ-014 wrap_pulse  output  1  registered one-cycle pulse after a wrap.
REQ-015 err  output  1  sticky illegal-load flag.
REQ-016 instr_cnt  output  ICW  count of completed instructions (rstsc events).

Function
REQ-017 Per-cycle priority for the count SHALL be rstsc, then ld, then inc, then hold.
REQ-018 rstsc high SHALL set DATA_out to 0 at the next edge, regardless of ld and inc.
REQ-019 ld high with ld_val < DEPTH and rstsc low SHALL set DATA_out to ld_val at the next edge.
REQ-020 ld high with ld_val >= DEPTH and rstsc low SHALL leave DATA_out unchanged, ignore inc that cycle, and set err at the next edge.
REQ-021 err SHALL stay high until rst.
REQ-022 inc alone with DATA_out < DEPTH-1 SHALL set DATA_out to DATA_out+1 at the next edge.
REQ-023 inc alone with DATA_out == DEPTH-1 and SAT_MODE=0 SHALL set DATA_out to 0 and assert wrap_pulse for exactly the following cycle.
REQ-024 inc alone with DATA_out == DEPTH-1 and SAT_MODE=1 SHALL hold DATA_out at DEPTH-1 with wrap_pulse low.
REQ-025 wrap_pulse SHALL be low in every cycle not directly following a wrap increment.
REQ-026 T_out SHALL be decoded combinationally from DATA_out with zero latency, bit DATA_out set, all others clear; exactly one bit high at all times.
REQ-027 tc SHALL be combinational from DATA_out with zero latency.
REQ-028 Each edge with rstsc high SHALL increment instr_cnt by 1, modulo 2^ICW, independent of ld and inc.
REQ-029 Arithmetic SHALL be unsigned; no intermediate value SHALL exceed WIDTH bits except the DEPTH comparison.

Reset
REQ-030 rst high SHALL immediately, without a clock edge, force DATA_out=0, wrap_pulse=0, err=0 and instr_cnt=0, giving T_out=1 (bit 0) and tc=0.
REQ-031 While rst is high, all other inputs SHALL be ignored.
REQ-032 rst asserted mid-sequence SHALL abandon the sequence; the first edge after rst deasserts SHALL apply normal priority from count 0.

Verification
REQ-033 Defaults, rst pulse then inc held 9 cycles -> DATA_out 0,1,...,7,0,1; T_out tracks one-hot; tc high only at 7; wrap_pulse high only in the cycle where DATA_out returns to 0.
REQ-034 SAT_MODE=1, inc held 10 cycles -> DATA_out sticks at 7, tc stays high, wrap_pulse never high.
REQ-035 At DATA_out=3, rstsc, ld (ld_val=5) and inc all high together -> DATA_out=0 next edge, instr_cnt +1.
REQ-036 DEPTH=6: ld with ld_val=7 at DATA_out=2, inc also high -> DATA_out stays 2, err=1 and stays 1; then ld_val=4 -> DATA_out=4, err still 1.
REQ-037 ICW=2, four rstsc pulses -> instr_cnt 1,2,3,0.
REQ-038 rst asserted between edges at DATA_out=5 -> DATA_out=0, T_out=1 and err=0 before the next edge; counting resumes 1,2 after release with inc high.

Source files
------------

// File: rtl/sc_timing_gen.sv
// Sequence-count timing generator: a modulo/saturating step counter with one-hot
// timing decode, terminal count, wrap pulse, sticky illegal-load flag and instruction counter.
module sc_timing_gen #(
   parameter int WIDTH    = 3,
   parameter int DEPTH    = 8,
   parameter int SAT_MODE = 0,
   parameter int ICW      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rstsc,
   input  logic             inc,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   output logic [WIDTH-1:0] DATA_out,
   output logic [DEPTH-1:0] T_out,
   output logic             tc,
   output logic             wrap_pulse,
   output logic             err,
   output logic [ICW-1:0]   instr_cnt
);

   localparam logic [WIDTH-1:0] LAST    = WIDTH'(DEPTH - 1);
   // One extra bit so DEPTH == 2**WIDTH still compares correctly.
   localparam logic [WIDTH:0]   DEPTH_X = (WIDTH+1)'(DEPTH);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             wrap_q, wrap_d;
   logic             err_q, err_d;
   logic [ICW-1:0]   icnt_q, icnt_d;
   logic             ld_ok;

   assign ld_ok = ({1'b0, ld_val} < DEPTH_X);

   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      err_d  = err_q;
      icnt_d = icnt_q;
      if (rstsc) begin
         cnt_d  = '0;
         icnt_d = icnt_q + 1'b1;
      end else if (ld) begin
         if (ld_ok) begin
            cnt_d = ld_val;
         end else begin
            err_d = 1'b1;
         end
      end else if (inc) begin
         if (cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
         end else if (SAT_MODE == 0) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
         icnt_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
         err_q  <= err_d;
         icnt_q <= icnt_d;
      end
   end

   assign DATA_out   = cnt_q;
   assign T_out      = DEPTH'(1) << cnt_q;
   assign tc         = (cnt_q == LAST);
   assign wrap_pulse = wrap_q;
   assign err        = err_q;
   assign instr_cnt  = icnt_q;

endmodule

// File: tb/tb_sc_timing_gen.sv
// Directed bench for sc_timing_gen: four instances (defaults, saturating, DEPTH=6, ICW=2)
// driven from one linear initial block with hand-computed expectations.
module tb_sc_timing_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rstsc_v [4];
   logic       inc_v   [4];
   logic       ld_v    [4];
   logic [2:0] ldval_v [4];

   logic [2:0] d_a, d_s, d_6, d_i;
   logic [7:0] t_a, t_s, t_i;
   logic [5:0] t_6;
   logic       tc_a, tc_s, tc_6, tc_i;
   logic       w_a, w_s, w_6, w_i;
   logic       e_a, e_s, e_6, e_i;
   logic [7:0] ic_a, ic_s, ic_6;
   logic [1:0] ic_i;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sc_timing_gen u_def (
      .clk(clk), .rst(rst), .rstsc(rstsc_v[0]), .inc(inc_v[0]), .ld(ld_v[0]), .ld_val(ldval_v[0]),
      .DATA_out(d_a), .T_out(t_a), .tc(tc_a), .wrap_pulse(w_a), .err(e_a), .instr_cnt(ic_a));

   sc_timing_gen #(.SAT_MODE(1)) u_sat (
      .clk(clk), .rst(rst), .rstsc(rstsc_v[1]), .inc(inc_v[1]), .ld(ld_v[1]), .ld_val(ldval_v[1]),
      .DATA_out(d_s), .T_out(t_s), .tc(tc_s), .wrap_pulse(w_s), .err(e_s), .instr_cnt(ic_s));

   sc_timing_gen #(.DEPTH(6)) u_d6 (
      .clk(clk), .rst(rst), .rstsc(rstsc_v[2]), .inc(inc_v[2]), .ld(ld_v[2]), .ld_val(ldval_v[2]),
      .DATA_out(d_6), .T_out(t_6), .tc(tc_6), .wrap_pulse(w_6), .err(e_6), .instr_cnt(ic_6));

   sc_timing_gen #(.ICW(2)) u_ic (
      .clk(clk), .rst(rst), .rstsc(rstsc_v[3]), .inc(inc_v[3]), .ld(ld_v[3]), .ld_val(ldval_v[3]),
      .DATA_out(d_i), .T_out(t_i), .tc(tc_i), .wrap_pulse(w_i), .err(e_i), .instr_cnt(ic_i));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] e;
      for (int i = 0; i < 4; i++) begin
         rstsc_v[i] = 1'b0; inc_v[i] = 1'b0; ld_v[i] = 1'b0; ldval_v[i] = 3'd0;
      end
      #1;
      // asynchronous reset state, before any clock edge
      chk("rst_data", 32'(d_a), 32'd0);
      chk("rst_tout", 32'(t_a), 32'h01);
      chk("rst_tc",   32'(tc_a), 32'd0);
      chk("rst_wrap", 32'(w_a), 32'd0);
      chk("rst_err",  32'(e_a), 32'd0);
      chk("rst_icnt", 32'(ic_a), 32'd0);

      // inputs ignored while rst is high
      inc_v[0] = 1'b1; inc_v[1] = 1'b1; rstsc_v[3] = 1'b1;
      step();
      chk("rst_hold_data", 32'(d_a), 32'd0);
      chk("rst_hold_icnt", 32'(ic_i), 32'd0);
      rstsc_v[3] = 1'b0;
      rst = 1'b0;

      // wrap (defaults) and saturate (SAT_MODE=1) with inc held
      for (int k = 1; k <= 10; k++) begin
         step();
         e = 3'(k % 8);
         chk("wrap_data", 32'(d_a), 32'(e));
         chk("wrap_tout", 32'(t_a), 32'(8'd1 << e));
         chk("wrap_tc",   32'(tc_a), 32'(e == 3'd7));
         chk("wrap_pulse", 32'(w_a), 32'(k == 8));
         chk("sat_data", 32'(d_s), (k >= 7) ? 32'd7 : 32'(k));
         chk("sat_tc",   32'(tc_s), 32'(k >= 7));
         chk("sat_wrap", 32'(w_s), 32'd0);
      end
      inc_v[1] = 1'b0;

      // count to 3, then rstsc+ld+inc together
      step();
      chk("pri_pre", 32'(d_a), 32'd3);
      rstsc_v[0] = 1'b1; ld_v[0] = 1'b1; ldval_v[0] = 3'd5;
      step();
      chk("pri_data", 32'(d_a), 32'd0);
      chk("pri_icnt", 32'(ic_a), 32'd1);
      chk("pri_tout", 32'(t_a), 32'h01);
      rstsc_v[0] = 1'b0; ld_v[0] = 1'b0; inc_v[0] = 1'b0;

      // DEPTH=6: illegal loads with inc, then legal load
      inc_v[2] = 1'b1;
      step(); step();
      chk("d6_pre", 32'(d_6), 32'd2);
      ld_v[2] = 1'b1; ldval_v[2] = 3'd7;
      step();
      chk("d6_ill_data", 32'(d_6), 32'd2);
      chk("d6_ill_err",  32'(e_6), 32'd1);
      ldval_v[2] = 3'd6;
      step();
      chk("d6_ill6_data", 32'(d_6), 32'd2);
      inc_v[2] = 1'b0; ldval_v[2] = 3'd4;
      step();
      chk("d6_ld_data", 32'(d_6), 32'd4);
      chk("d6_ld_err",  32'(e_6), 32'd1);
      ld_v[2] = 1'b0; inc_v[2] = 1'b1;
      step();
      chk("d6_tc_data", 32'(d_6), 32'd5);
      chk("d6_tc",      32'(tc_6), 32'd1);
      chk("d6_tout",    32'(t_6), 32'h20);
      step();
      chk("d6_wrap_data", 32'(d_6), 32'd0);
      chk("d6_wrap",      32'(w_6), 32'd1);
      inc_v[2] = 1'b0;
      step();
      chk("d6_wrap_low", 32'(w_6), 32'd0);
      chk("d6_err_stk",  32'(e_6), 32'd1);

      // ICW=2 instruction counter rollover
      rstsc_v[3] = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("icw2_cnt", 32'(ic_i), 32'(k % 4));
      end
      rstsc_v[3] = 1'b0;

      // async reset mid-sequence at count 5
      inc_v[0] = 1'b1;
      for (int k = 1; k <= 5; k++) step();
      chk("mid_pre", 32'(d_a), 32'd5);
      rst = 1'b1;
      #1;
      chk("mid_data", 32'(d_a), 32'd0);
      chk("mid_tout", 32'(t_a), 32'h01);
      chk("mid_tc",   32'(tc_a), 32'd0);
      chk("mid_err",  32'(e_6), 32'd0);
      chk("mid_icnt", 32'(ic_a), 32'd0);
      step();
      rst = 1'b0;
      step();
      chk("resume1", 32'(d_a), 32'd1);
      step();
      chk("resume2", 32'(d_a), 32'd2);
      inc_v[0] = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
